// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, memory-busy freeze and
// saturating stall/flush counters. Define HAZ_NOFWD_EN for a core built without forwarding.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_bubble,
    output logic             exmem_stall,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   pend_flush, pend_flush_nxt;
    logic   rs1_ex, rs2_ex, ldu, hz;
    logic   pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c, idex_bubble_c, exmem_stall_c;

    assign rs1_ex = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_ex = id_use_rs2 && (id_rs2 == ex_rd);
    assign ldu    = ex_memread && (ex_rd != 5'd0) && (rs1_ex || rs2_ex);

`ifdef HAZ_NOFWD_EN
    logic raw_ex, raw_mem;
    assign raw_ex  = ex_regwrite && (ex_rd != 5'd0) && (rs1_ex || rs2_ex);
    assign raw_mem = mem_regwrite && (mem_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
    assign hz      = ldu || raw_ex || raw_mem;
`else
    // Forwarding covers ALU producers, so only loads need a stall.
    logic unused_fwd;
    assign unused_fwd = ^{ex_regwrite, mem_regwrite, mem_rd};
    assign hz         = ldu;
`endif

    // NOTE: every variable gets a default before the case so no latch can be inferred.
    always_comb begin
        state_nxt      = state;
        pend_flush_nxt = pend_flush;
        pc_stall_c     = 1'b0;
        ifid_stall_c   = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_stall_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        exmem_stall_c  = 1'b0;

        if (mem_busy) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_stall_c  = 1'b1;
            exmem_stall_c = 1'b1;
            state_nxt     = MEM_WAIT;
            if (ex_redirect) pend_flush_nxt = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        // Instruction in ID is wrong-path; any ldu it raises is moot.
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                    end else if (hz) begin
                        pc_stall_c    = 1'b1;
                        ifid_stall_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    pend_flush_nxt = pend_flush || ex_redirect;
                    state_nxt      = (pend_flush || ex_redirect) ? FLUSH : RUN;
                end
                FLUSH: begin
                    // A redirect landing here is absorbed into this single flush.
                    ifid_flush_c   = 1'b1;
                    idex_bubble_c  = 1'b1;
                    pend_flush_nxt = 1'b0;
                    state_nxt      = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // NOTE: outputs are gated by nrst so the pipeline sees no stall or flush during reset,
    // even though they are otherwise purely combinational from state and inputs.
    assign pc_stall    = nrst & pc_stall_c;
    assign ifid_stall  = nrst & ifid_stall_c;
    assign ifid_flush  = nrst & ifid_flush_c;
    assign idex_stall  = nrst & idex_stall_c;
    assign idex_bubble = nrst & idex_bubble_c;
    assign exmem_stall = nrst & exmem_stall_c;
    assign hz_state    = state;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= RUN;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend_flush <= pend_flush_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; a second 2-bit-counter instance checks saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, mem_regwrite;
    logic        ex_redirect, mem_busy, clr_cnt;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall;
    logic [1:0]  hz_state;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc, s_ifs, s_iff, s_ids, s_idb, s_ems;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // Control vector order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_FRZ   = 6'b110101;
    localparam logic [5:0] C_LDU   = 6'b110010;
    localparam logic [5:0] C_FLUSH = 6'b001010;
`ifdef HAZ_NOFWD_EN
    localparam logic [5:0] C_ALU   = C_LDU;
    localparam int         ALU_N   = 2;
`else
    localparam logic [5:0] C_ALU   = C_NONE;
    localparam int         ALU_N   = 0;
`endif

    logic [5:0] ctl;
    assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .nrst(nrst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .clr_cnt(clr_cnt), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_bubble(idex_bubble),
        .exmem_stall(exmem_stall), .hz_state(hz_state), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .nrst(nrst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .clr_cnt(clr_cnt), .pc_stall(s_pc), .ifid_stall(s_ifs),
        .ifid_flush(s_iff), .idex_stall(s_ids), .idex_bubble(s_idb),
        .exmem_stall(s_ems), .hz_state(s_state), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_regwrite = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0;
        ex_redirect = 1'b0; mem_busy = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        idle();
        mem_busy = 1'b1;
        #12;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_NONE); end
        n_cmp++; if (hz_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d want=0", hz_state); end
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
        mem_busy = 1'b0;
        nrst = 1'b1;
        tick();
        n_cmp++; if (ctl !== C_NONE || hz_state !== 2'd0) begin
            n_err++; $display("FAIL post_reset got=%b/%0d want=%b/0", ctl, hz_state, C_NONE); end
    endtask

    task automatic test_load_use();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_LDU) begin n_err++; $display("FAIL ldu_rs1 got=%b want=%b", ctl, C_LDU); end
        tick(); exp_stall++;
        idle();
        #2;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL ldu_gone got=%b want=%b", ctl, C_NONE); end
        n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin
            n_err++; $display("FAIL ldu_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_LDU) begin n_err++; $display("FAIL ldu_rs2 got=%b want=%b", ctl, C_LDU); end
        tick(); exp_stall++;
        id_use_rs2 = 1'b0;
        #2;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL ldu_unused_src got=%b want=%b", ctl, C_NONE); end
        id_use_rs2 = 1'b1; ex_memread = 1'b0;
        #2;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL ldu_no_memread got=%b want=%b", ctl, C_NONE); end
        tick();
        n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin
            n_err++; $display("FAIL ldu_cnt2 got=%0d want=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_x0();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL x0_ctl got=%b want=%b", ctl, C_NONE); end
        tick();
        n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin
            n_err++; $display("FAIL x0_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_redirect_ldu();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_FLUSH) begin n_err++; $display("FAIL redir_ctl got=%b want=%b", ctl, C_FLUSH); end
        tick(); exp_flush++;
        idle();
        #2;
        n_cmp++; if (flush_cnt !== 32'(exp_flush) || stall_cnt !== 32'(exp_stall)) begin
            n_err++; $display("FAIL redir_cnt got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); end
        n_cmp++; if (hz_state !== 2'd0) begin n_err++; $display("FAIL redir_state got=%0d want=0", hz_state); end
    endtask

    task automatic test_saturation();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1; clr_cnt = 1'b1;
        tick();
        n_cmp++; if (stall_cnt !== 32'd0 || s_stall_cnt !== 2'd0) begin
            n_err++; $display("FAIL clr_wins got=%0d/%0d want=0/0", stall_cnt, s_stall_cnt); end
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL sat_stall_wide got=%0d want=5", stall_cnt); end
        n_cmp++; if (s_stall_cnt !== 2'd3) begin n_err++; $display("FAIL sat_stall got=%0d want=3", s_stall_cnt); end
        idle();
        ex_redirect = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (flush_cnt !== 32'd4 || s_flush_cnt !== 2'd3) begin
            n_err++; $display("FAIL sat_flush got=%0d/%0d want=4/3", flush_cnt, s_flush_cnt); end
        idle();
    endtask

    task automatic test_busy_redirect();
        idle();
        clear_counters();
        mem_busy = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_FRZ || hz_state !== 2'd0) begin
            n_err++; $display("FAIL busy1 got=%b/%0d want=%b/0", ctl, hz_state, C_FRZ); end
        tick();
        ex_redirect = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_FRZ || hz_state !== 2'd1) begin
            n_err++; $display("FAIL busy2 got=%b/%0d want=%b/1", ctl, hz_state, C_FRZ); end
        tick();
        ex_redirect = 1'b0;
        #2;
        n_cmp++; if (ctl !== C_FRZ || hz_state !== 2'd1) begin
            n_err++; $display("FAIL busy3 got=%b/%0d want=%b/1", ctl, hz_state, C_FRZ); end
        tick();
        mem_busy = 1'b0;
        #2;
        n_cmp++; if (ctl !== C_NONE || hz_state !== 2'd1) begin
            n_err++; $display("FAIL memwait got=%b/%0d want=%b/1", ctl, hz_state, C_NONE); end
        tick();
        ex_redirect = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_FLUSH || hz_state !== 2'd2) begin
            n_err++; $display("FAIL flush_state got=%b/%0d want=%b/2", ctl, hz_state, C_FLUSH); end
        tick();
        ex_redirect = 1'b0;
        #2;
        n_cmp++; if (ctl !== C_NONE || hz_state !== 2'd0) begin
            n_err++; $display("FAIL back_run got=%b/%0d want=%b/0", ctl, hz_state, C_NONE); end
        n_cmp++; if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
            n_err++; $display("FAIL busy_cnt got=%0d/%0d want=3/1", stall_cnt, flush_cnt); end
    endtask

    task automatic test_nofwd();
        idle();
        clear_counters();
        ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #2;
        n_cmp++; if (ctl !== C_ALU) begin n_err++; $display("FAIL alu_ex got=%b want=%b", ctl, C_ALU); end
        tick();
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd7;
        #2;
        n_cmp++; if (ctl !== C_ALU) begin n_err++; $display("FAIL alu_mem got=%b want=%b", ctl, C_ALU); end
        tick();
        mem_regwrite = 1'b0;
        #2;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL alu_done got=%b want=%b", ctl, C_NONE); end
        mem_regwrite = 1'b1; mem_rd = 5'd0; id_rs2 = 5'd0;
        #2;
        n_cmp++; if (ctl !== C_NONE) begin n_err++; $display("FAIL alu_x0 got=%b want=%b", ctl, C_NONE); end
        tick();
        n_cmp++; if (stall_cnt !== 32'(ALU_N)) begin
            n_err++; $display("FAIL alu_cnt got=%0d want=%0d", stall_cnt, ALU_N); end
    endtask

    task automatic test_async_reset();
        idle();
        mem_busy = 1'b1;
        tick();
        n_cmp++; if (hz_state !== 2'd1) begin n_err++; $display("FAIL pre_rst_state got=%0d want=1", hz_state); end
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++; if (ctl !== C_NONE || hz_state !== 2'd0) begin
            n_err++; $display("FAIL async_rst got=%b/%0d want=%b/0", ctl, hz_state, C_NONE); end
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || s_stall_cnt !== 2'd0) begin
            n_err++; $display("FAIL async_cnt got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, s_stall_cnt); end
        mem_busy = 1'b0;
        #1;
        nrst = 1'b1;
        tick();
        n_cmp++; if (ctl !== C_NONE || hz_state !== 2'd0) begin
            n_err++; $display("FAIL after_rst got=%b/%0d want=%b/0", ctl, hz_state, C_NONE); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_redirect_ldu();
        test_saturation();
        test_busy_redirect();
        test_nofwd();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the hold and kill controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Consumes the ID/EX register outputs (EX-stage rd, MemRead, RegWrite), the ID-stage source registers, the EX branch/jump redirect pulse and the data-memory busy flag.
- Produces stall, flush and bubble controls plus saturating performance counters.
- Sits beside the pipeline registers in the core top level.

Parameters:
- CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  input  1  core clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- id_rs1  input  5  rs1 field (inst[19:15]) of the instruction in ID.
- id_rs2  input  5  rs2 field (inst[24:20]) of the instruction in ID.
- id_use_rs1  input  1  instruction in ID reads rs1.
- id_use_rs2  input  1  instruction in ID reads rs2.
- ex_rd  input  5  rd field of the ID/EX register output.
- ex_memread  input  1  MemRead of the ID/EX register output.
- ex_regwrite  input  1  RegWrite of the ID/EX register output.
- mem_rd  input  5  rd of the EX/MEM register output.
- mem_regwrite  input  1  RegWrite of the EX/MEM register output.
- ex_redirect  input  1  single-cycle pulse: taken branch or jump resolved in EX.
- mem_busy  input  1  data memory not ready; the pipeline must freeze.
- clr_cnt  input  1  synchronous clear of both counters.
- pc_stall  output  1  hold PC.
- ifid_stall  output  1  hold IF/ID.
- ifid_flush  output  1  zero IF/ID (insert NOP).
- idex_stall  output  1  hold ID/EX.
- idex_bubble  output  1  load all-zero control signals into ID/EX.
- exmem_stall  output  1  hold EX/MEM.
- hz_state  output  2  current FSM state.
- stall_cnt  output  CNT_W  number of cycles with pc_stall=1, saturating.
- flush_cnt  output  CNT_W  number of flush events, saturating.

Behaviour:
- Reset is asynchronous: state=RUN, pend_flush=0, counters=0.
- While nrst=0, all stall, flush and bubble outputs are 0 and hz_state=0.
- Stall, flush and bubble outputs are combinational from the state and the current inputs. State and counters update on posedge clk.
- A register address of x0 never causes a hazard.
- Load-use hazard (ldu): ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- FSM states: RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2. Value 2'd3 is illegal and recovers to RUN on the next edge.
- Output priority within any cycle: mem_busy > redirect (ex_redirect or FLUSH state) > ldu.
- Any state with mem_busy=1 (freeze):
  - pc_stall, ifid_stall, idex_stall, exmem_stall = 1.
  - ifid_flush and idex_bubble = 0.
  - Next state is MEM_WAIT.
  - If ex_redirect=1 in this cycle, pend_flush is set to 1.
- RUN with mem_busy=0:
  - If ex_redirect=1: ifid_flush=1 and idex_bubble=1 in the same cycle, all stalls 0, flush_cnt+1. An ldu in this cycle is ignored (wrong-path instruction).
  - Else if ldu: pc_stall=1, ifid_stall=1, idex_bubble=1 for exactly the one cycle the hazard is present.
  - Else all outputs 0.
- MEM_WAIT with mem_busy=0:
  - Outputs are all 0. No ldu or redirect evaluation is needed here; if ex_redirect=1, pend_flush is set.
  - Next state is FLUSH if pend_flush (including one set this cycle), else RUN.
- FLUSH with mem_busy=0:
  - ifid_flush=1, idex_bubble=1, flush_cnt+1, pend_flush cleared, next state RUN.
  - An ex_redirect arriving in this cycle is merged; no second flush is issued.
- Counters:
  - stall_cnt increments on every edge where pc_stall=1.
  - Both counters saturate at all-ones.
  - clr_cnt wins over increment.

Optional Feature:
- Macro HAZ_NOFWD_EN selects a core built without forwarding.
- Defined: the RUN-state hazard condition is widened to ldu, OR ex_regwrite & ex_rd!=0 matching a used source, OR mem_regwrite & mem_rd!=0 matching a used source.
  - The widened condition causes the same stall-and-bubble response as ldu.
  - The stall repeats every cycle while the condition holds: up to 2 cycles for an ALU producer.
- Undefined: only ldu stalls; mem_rd and mem_regwrite are ignored.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall=ifid_stall=idex_bubble=1 for 1 cycle, stall_cnt=1.
- x0 producer: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall; stall_cnt stays 0.
- Redirect with simultaneous ldu: ex_redirect=1 and ldu in the same cycle -> ifid_flush=idex_bubble=1, pc_stall=0, flush_cnt=1.
- Redirect during busy: mem_busy=1 for 3 cycles, ex_redirect pulsed in busy cycle 2 -> all four stalls=1 for 3 cycles, hz_state=1, then FLUSH (hz_state=2) with ifid_flush=1 for 1 cycle, then RUN. Final counts: stall_cnt=3, flush_cnt=1.
- Async reset mid-MEM_WAIT: nrst low between clock edges -> outputs 0 immediately, hz_state=0, counters 0.
- HAZ_NOFWD_EN: ex_regwrite=1, ex_rd=7, id_rs2=7, id_use_rs2=1, with the producer then advancing to mem_rd=7 -> 2 consecutive stall cycles; with the macro undefined, 0 stall cycles.
